// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between the IF/D requesters, the arbiter and the unified memory.
// slave is the arbiter's view; master is the view of everything around it.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic            if_req;
  logic [AW-1:0]   if_addr;
  logic [DW-1:0]   if_rdata;
  logic            if_ack;

  logic            d_req;
  logic            d_we;
  logic [AW-1:0]   d_addr;
  logic [DW-1:0]   d_wdata;
  logic [DW/8-1:0] d_be;
  logic [DW-1:0]   d_rdata;
  logic            d_ack;
  logic            bus_err;

  logic            m_req;
  logic            m_we;
  logic [AW-1:0]   m_addr;
  logic [DW-1:0]   m_wdata;
  logic [DW/8-1:0] m_be;
  logic [DW-1:0]   m_rdata;
  logic            m_ready;

  // Handshake: a requester holds req (and its address/data) until its one-cycle
  // ack; the arbiter holds m_req and m_* stable until m_ready is sampled high.
  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, m_rdata, m_ready,
    output if_rdata, if_ack, d_rdata, d_ack, bus_err,
    output m_req, m_we, m_addr, m_wdata, m_be
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, m_rdata, m_ready,
    input  if_rdata, if_ack, d_rdata, d_ack, bus_err,
    input  m_req, m_we, m_addr, m_wdata, m_be
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: D-over-IF priority with an IF starvation guard,
// one transaction in flight, timeout abort with bus_err.
module mem_port_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mem_port_arbiter_if.slave    bus,
  output logic [1:0]           dbg_state
);
  localparam int BW = DW / 8;
  localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [SW-1:0] S_MAX   = SW'(STARVE_LIMIT);
  localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;

  logic            owner_d;
  logic            err_q;
  logic            we_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q;
  logic [BW-1:0]   be_q;
  logic [TW-1:0]   to_cnt;
  logic [SW-1:0]   starve_cnt;
  logic [DW-1:0]   if_rdata_q;
  logic [DW-1:0]   d_rdata_q;

  logic            grant_d;
  logic            grant_if;
  logic            timed_out;
  logic            busy;

  // IF only overrides D once D has won STARVE_LIMIT times in a row with IF waiting.
  assign grant_d   = bus.d_req && (!bus.if_req || (starve_cnt != S_MAX));
  assign grant_if  = bus.if_req && !grant_d;
  assign timed_out = (TIMEOUT != 0) && !bus.m_ready && (to_cnt == TO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_d || grant_if) state_nxt = BUSY;
      BUSY:    if (bus.m_ready || timed_out) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_d    <= 1'b0;
      err_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      to_cnt     <= '0;
      starve_cnt <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_d || grant_if) begin
            owner_d <= grant_d;
            err_q   <= 1'b0;
            to_cnt  <= '0;
            we_q    <= grant_d && bus.d_we;
            addr_q  <= grant_d ? bus.d_addr : bus.if_addr;
            wdata_q <= grant_d ? bus.d_wdata : '0;
            be_q    <= grant_d ? bus.d_be : '1;
            if (grant_d && bus.if_req) begin
              starve_cnt <= (starve_cnt == S_MAX) ? starve_cnt : starve_cnt + 1'b1;
            end else begin
              starve_cnt <= '0;
            end
          end
        end
        BUSY: begin
          if (bus.m_ready) begin
            if (!we_q) begin
              if (owner_d) d_rdata_q  <= bus.m_rdata;
              else         if_rdata_q <= bus.m_rdata;
            end
          end else if (timed_out) begin
            err_q <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Memory-side outputs are gated by state so they read zero outside BUSY
  // and collapse the moment rst_n falls.
  assign busy        = (state == BUSY);
  assign bus.m_req   = busy;
  assign bus.m_we    = busy && we_q;
  assign bus.m_addr  = busy ? addr_q : '0;
  assign bus.m_wdata = busy ? wdata_q : '0;
  assign bus.m_be    = busy ? be_q : '0;

  assign bus.if_ack   = (state == DONE) && !owner_d;
  assign bus.d_ack    = (state == DONE) && owner_d;
  assign bus.bus_err  = (state == DONE) && err_q;
  assign bus.if_rdata = if_rdata_q;
  assign bus.d_rdata  = d_rdata_q;

  assign dbg_state = state;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: scoreboard queues for acks and memory
// requests, checked by monitors independent of the stimulus tasks.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int TIMEOUT = 64;
  localparam int EW = DW + 3;
  localparam int MW = 1 + AW + DW + BW + 16;
  localparam logic [31:0] KEY  = 32'h5A5A_5A5A;
  localparam logic [31:0] IF_A = 32'h0000_1000;
  localparam logic [31:0] D_A  = 32'h0000_2000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] dbg_state;

  mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mem_port_arbiter #(
    .AW(AW), .DW(DW), .STARVE_LIMIT(4), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_miss = 0;
  logic [EW-1:0] exp_q[$];
  logic [MW-1:0] mem_q[$];
  int          mem_wait = 0;
  bit          use_fixed = 1'b0;
  logic [31:0] rdata_fixed = '0;
  logic [31:0] last_if = '0;
  logic [31:0] last_d = '0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic zero_chk(input string tag);
    check({tag, "_ctrl"}, {bus.m_req, bus.m_we, bus.m_be, bus.if_ack, bus.d_ack, bus.bus_err, dbg_state}, '0);
    check({tag, "_mbus"}, {bus.m_addr, bus.m_wdata}, '0);
    check({tag, "_rdata"}, {bus.if_rdata, bus.d_rdata}, '0);
  endtask

  // ack monitor
  initial begin
    logic [EW-1:0] e;
    forever begin
      @(negedge clk);
      if (bus.if_ack || bus.d_ack) begin
        if (exp_q.size() == 0) begin
          check("unexpected_ack", {bus.if_ack, bus.d_ack}, '0);
        end else begin
          e = exp_q.pop_front();
          check("ack", {bus.if_ack, bus.d_ack, bus.bus_err,
                        (e[EW-1 -: 2] == 2'b01) ? bus.d_rdata : bus.if_rdata}, e);
        end
      end
    end
  end

  // memory model and m_* monitor
  initial begin
    int mcnt;
    bit stable;
    logic [MW-1:0] m;
    logic [MW-17:0] snap;
    logic [15:0] cur_len;
    mcnt = 0;
    stable = 1'b1;
    snap = '0;
    cur_len = '0;
    forever begin
      @(negedge clk);
      if (bus.m_req) begin
        if (mcnt == 0) begin
          snap = {bus.m_we, bus.m_addr, bus.m_wdata, bus.m_be};
          stable = 1'b1;
          if (mem_q.size() == 0) begin
            check("unexpected_mreq", bus.m_req, '0);
            cur_len = '0;
          end else begin
            m = mem_q.pop_front();
            check("mem_fields", snap, m[MW-1:16]);
            cur_len = m[15:0];
          end
        end else if (snap !== {bus.m_we, bus.m_addr, bus.m_wdata, bus.m_be}) begin
          stable = 1'b0;
        end
        bus.m_ready = (mcnt == mem_wait);
        bus.m_rdata = use_fixed ? rdata_fixed : (bus.m_addr ^ KEY);
        mcnt++;
      end else begin
        bus.m_ready = 1'b0;
        if (mcnt != 0) begin
          check("mreq_len_stable", {mcnt[15:0], stable}, {cur_len, 1'b1});
          mcnt = 0;
        end
      end
    end
  end

  // driver tasks
  task automatic wait_ack(output int cyc);
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
    end while (!(bus.if_ack || bus.d_ack) && cyc < 300);
    if (!(bus.if_ack || bus.d_ack)) begin
      n_vec++;
      n_miss++;
      $display("FAIL ack_wait: no ack after %0d cycles, one required", cyc);
    end
  endtask

  task automatic single(input bit is_d, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be,
                        input int wt, input bit err);
    int len;
    int cyc;
    logic [31:0] rd;
    len = err ? TIMEOUT : wt + 1;
    rd = use_fixed ? rdata_fixed : (addr ^ KEY);
    mem_wait = err ? 100000 : wt;
    if (is_d) begin
      if (!we && !err) last_d = rd;
      exp_q.push_back({2'b01, err, last_d});
      mem_q.push_back({we, addr, wdata, be, 16'(len)});
      bus.d_we = we;
      bus.d_addr = addr;
      bus.d_wdata = wdata;
      bus.d_be = be;
      bus.d_req = 1'b1;
    end else begin
      if (!err) last_if = rd;
      exp_q.push_back({2'b10, err, last_if});
      mem_q.push_back({1'b0, addr, 32'h0, 4'hF, 16'(len)});
      bus.if_addr = addr;
      bus.if_req = 1'b1;
    end
    wait_ack(cyc);
    check("latency", cyc, len + 1);
    bus.if_req = 1'b0;
    bus.d_req = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Both requesters contend; order bit k = 1 means grant k goes to D.
  task automatic stream(input int n, input logic [15:0] order);
    int cyc;
    bus.if_addr = IF_A;
    bus.d_addr = D_A;
    bus.d_we = 1'b0;
    bus.d_wdata = '0;
    bus.d_be = 4'hF;
    mem_wait = 0;
    use_fixed = 1'b0;
    bus.if_req = 1'b1;
    bus.d_req = 1'b1;
    for (int k = 0; k < n; k++) begin
      if (order[k]) begin
        last_d = D_A ^ KEY;
        exp_q.push_back({2'b01, 1'b0, last_d});
        mem_q.push_back({1'b0, D_A, 32'h0, 4'hF, 16'd1});
      end else begin
        last_if = IF_A ^ KEY;
        exp_q.push_back({2'b10, 1'b0, last_if});
        mem_q.push_back({1'b0, IF_A, 32'h0, 4'hF, 16'd1});
      end
      wait_ack(cyc);
      if (k == n - 1) begin
        bus.if_req = 1'b0;
        bus.d_req = 1'b0;
      end else if (bus.d_ack) begin
        bus.d_req = 1'b0;
      end else begin
        bus.if_req = 1'b0;
      end
      @(posedge clk);
      #1;
      if (k != n - 1) begin
        bus.if_req = 1'b1;
        bus.d_req = 1'b1;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc;
    bus.if_req = 1'b1;
    bus.d_req = 1'b1;
    bus.if_addr = IF_A;
    bus.d_addr = D_A;
    bus.d_we = 1'b0;
    bus.d_wdata = '0;
    bus.d_be = 4'hF;
    bus.m_ready = 1'b0;
    bus.m_rdata = '0;

    // reset held with both requests pending, then D first and D,D,D,D,I twice
    repeat (3) @(posedge clk);
    #1;
    zero_chk("reset");
    rst_n = 1'b1;
    stream(10, 16'h01EF);

    // IF read, zero-wait memory
    use_fixed = 1'b1;
    rdata_fixed = 32'h8C01_0004;
    single(1'b0, 1'b0, 32'h0040_0000, 32'h0, 4'h0, 0, 1'b0);
    use_fixed = 1'b0;

    // D write with 3 wait states leaves d_rdata alone; then a D read updates it
    single(1'b1, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'h3, 3, 1'b0);
    single(1'b1, 1'b0, 32'h0000_0020, 32'h0, 4'hF, 1, 1'b0);

    // hung memory aborts after TIMEOUT cycles; m_ready on the last cycle completes normally
    single(1'b0, 1'b0, 32'h0000_0300, 32'h0, 4'h0, 0, 1'b1);
    single(1'b1, 1'b0, 32'h0000_0400, 32'h0, 4'hF, TIMEOUT - 1, 1'b0);
    single(1'b1, 1'b1, 32'h0000_0500, 32'h1234_5678, 4'hC, 0, 1'b0);

    // build starve_cnt to 4, abort mid-BUSY, and confirm arbitration restarts from 0
    stream(3, 16'h0007);
    bus.if_req = 1'b1;
    bus.d_req = 1'b1;
    mem_wait = 100000;
    mem_q.push_back({1'b0, D_A, 32'h0, 4'hF, 16'd5});
    cyc = 0;
    while (!bus.m_req && cyc < 10) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("abort_mreq_seen", bus.m_req, 1'b1);
    repeat (5) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    zero_chk("reset_mid");
    last_if = '0;
    last_d = '0;
    mem_wait = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    stream(5, 16'h000F);

    repeat (3) @(posedge clk);
    #1;
    check("exp_q_empty", exp_q.size(), 0);
    check("mem_q_empty", mem_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
